// File: rtl/line_mem_responder_pkg.sv
// Shared sizing constants, state encoding and helpers for the line-burst memory responder.
// Defaults describe a 64 KiB store serving 32-byte lines as four 64-bit beats.
package line_mem_pkg;

  localparam int DEF_ADDR_BITS  = 16;
  localparam int DEF_LINE_BYTES = 32;
  localparam int DEF_BEAT_BYTES = 8;
  localparam int DEF_RD_LATENCY = 4;
  localparam int DEF_WR_LATENCY = 2;

  localparam int BEATS         = DEF_LINE_BYTES / DEF_BEAT_BYTES;
  localparam int OFFSET_BITS   = $clog2(DEF_LINE_BYTES);
  localparam int BEAT_IDX_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LAT   = 3'd1,
    ST_RBEAT = 3'd2,
    ST_WBEAT = 3'd3,
    ST_WREL  = 3'd4
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_mem_responder_if.sv
// Cache line-burst bus between the L1 controller (master) and main memory (slave).
// All strobes are single-cycle pulses; the master holds mem_req for the whole burst.
interface line_mem_if #(
  parameter int ADDR_BITS = 16
);

  logic                 mem_req;
  logic                 mem_wr;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [63:0]          mem_wdata;
  logic [63:0]          rdata;
  logic                 rvalid;
  logic                 ready;
  logic                 done;
  logic                 busy;

  modport master (
    output mem_req, mem_wr, mem_addr, mem_wdata,
    input  rdata, rvalid, ready, done, busy
  );

  modport slave (
    input  mem_req, mem_wr, mem_addr, mem_wdata,
    output rdata, rvalid, ready, done, busy
  );

endinterface

// File: rtl/line_mem_responder_beat_array.sv
// Single-port 64-bit word store: synchronous write, one-cycle synchronous read, write wins.
// load/peek give benches direct access to the array without going through the bus.
module mem_beat_array #(
  parameter int WORD_BITS = 13
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [WORD_BITS-1:0] word,
  input  logic [63:0]          wdat,
  output logic [63:0]          rdat
);

  logic [63:0] mem [2**WORD_BITS];

  // Contents deliberately survive reset; only the controller state is cleared.
  always @(posedge clk) begin
    if (we) begin
      mem[word] <= wdat;
    end else if (en) begin
      rdat <= mem[word];
    end
  end

  task automatic load(input logic [WORD_BITS-1:0] idx, input logic [63:0] dat);
    mem[idx] <= dat;
  endtask

  function automatic logic [63:0] peek(input logic [WORD_BITS-1:0] idx);
    return mem[idx];
  endfunction

endmodule

// File: rtl/line_mem_responder.sv
// Main-memory end of the cache line-burst bus: serves fills and absorbs writebacks beat by beat
// after a fixed access latency; a burst ends when the initiator releases mem_req.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int ADDR_BITS  = DEF_ADDR_BITS,
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int BEAT_BYTES = DEF_BEAT_BYTES,
  parameter int RD_LATENCY = DEF_RD_LATENCY,
  parameter int WR_LATENCY = DEF_WR_LATENCY
) (
  input  logic       clk,
  input  logic       rst,
  line_mem_if.slave  bus
);

  localparam int NBEATS     = LINE_BYTES / BEAT_BYTES;
  localparam int OFS_BITS   = $clog2(LINE_BYTES);
  localparam int WORD_BITS  = ADDR_BITS - 3;
  localparam int LINE_BITS  = ADDR_BITS - OFS_BITS;
  localparam int BEAT_SHIFT = OFS_BITS - 3;
  localparam int BIDX_BITS  = idx_bits(NBEATS);
  localparam int LAT_MAX    = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int LAT_BITS   = idx_bits(LAT_MAX);

  localparam logic [BIDX_BITS-1:0] LAST_BEAT = BIDX_BITS'(NBEATS - 1);
  localparam logic [BIDX_BITS-1:0] BEAT_ONE  = BIDX_BITS'(1);
  localparam logic [LAT_BITS-1:0]  RD_LOAD   = LAT_BITS'(RD_LATENCY - 1);
  localparam logic [LAT_BITS-1:0]  WR_LOAD   = LAT_BITS'(WR_LATENCY - 1);
  localparam logic [LAT_BITS-1:0]  LAT_ONE   = LAT_BITS'(1);

  state_t                 state_q, state_d;
  logic [LAT_BITS-1:0]    lat_q, lat_d;
  logic [BIDX_BITS-1:0]   beat_q, beat_d;
  logic [BIDX_BITS-1:0]   beat_nxt;
  logic                   phase_q, phase_d;
  logic                   wr_q;
  logic [LINE_BITS-1:0]   line_q;
  logic                   accept;

  logic                   ram_re;
  logic                   ram_we;
  logic [WORD_BITS-1:0]   ram_word;
  logic [WORD_BITS-1:0]   base_word;
  logic [63:0]            ram_dout;

  logic                   rvalid_i;
  logic                   ready_i;

  // Offset bits inside the line never select anything: every burst starts at beat 0.
  logic unused_ofs;
  assign unused_ofs = ^bus.mem_addr[OFS_BITS-1:0];

  assign base_word = WORD_BITS'(line_q) << BEAT_SHIFT;
  assign beat_nxt  = beat_q + BEAT_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      phase_q <= 1'b0;
      wr_q    <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      phase_q <= phase_d;
      if (accept) begin
        wr_q   <= bus.mem_wr;
        line_q <= bus.mem_addr[ADDR_BITS-1:OFS_BITS];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    beat_d   = beat_q;
    phase_d  = phase_q;
    accept   = 1'b0;
    ram_re   = 1'b0;
    ram_we   = 1'b0;
    ram_word = base_word | WORD_BITS'(beat_q);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_req) begin
          accept  = 1'b1;
          state_d = ST_LAT;
          lat_d   = bus.mem_wr ? WR_LOAD : RD_LOAD;
          beat_d  = '0;
          phase_d = 1'b0;
        end
      end

      ST_LAT: begin
        if (!bus.mem_req) begin
          state_d = ST_IDLE;
        end else if (lat_q == '0) begin
          if (wr_q) begin
            state_d = ST_WBEAT;
          end else begin
            // Sync RAM: beat 0 is fetched one cycle ahead of its rvalid.
            ram_re  = 1'b1;
            state_d = ST_RBEAT;
          end
        end else begin
          lat_d = lat_q - LAT_ONE;
        end
      end

      ST_RBEAT: begin
        if (!bus.mem_req) begin
          state_d = ST_IDLE;
        end else if (beat_q == LAST_BEAT) begin
          state_d = ST_WREL;
        end else begin
          ram_re   = 1'b1;
          ram_word = base_word | WORD_BITS'(beat_nxt);
          beat_d   = beat_nxt;
        end
      end

      ST_WBEAT: begin
        // A ready pulse commits on its own edge even if the initiator is releasing.
        ram_we = !phase_q;
        if (!bus.mem_req) begin
          state_d = ST_IDLE;
        end else if (!phase_q) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_WREL;
          end else begin
            beat_d  = beat_nxt;
            phase_d = 1'b1;
          end
        end else begin
          phase_d = 1'b0;
        end
      end

      ST_WREL: begin
        if (!bus.mem_req) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  mem_beat_array #(
    .WORD_BITS (WORD_BITS)
  ) u_arr (
    .clk  (clk),
    .en   (ram_re),
    .we   (ram_we),
    .word (ram_word),
    .wdat (bus.mem_wdata),
    .rdat (ram_dout)
  );

  assign rvalid_i   = (state_q == ST_RBEAT);
  assign ready_i    = (state_q == ST_WBEAT) && !phase_q;

  assign bus.rvalid = rvalid_i;
  assign bus.ready  = ready_i;
  assign bus.done   = (rvalid_i || ready_i) && (beat_q == LAST_BEAT);
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.rdata  = rvalid_i ? ram_dout : '0;

endmodule
